// File: rtl/truth_table_scanner.sv
// Stimulus/response engine for 4-input combinational blocks: drives all 16 input
// rows, samples the response after a settle delay and compares it to an expected table.
module truth_table_scanner #(
   parameter int SETTLE = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] exp_table,
   input  logic        f_in,
   output logic        w_out,
   output logic        x_out,
   output logic        y_out,
   output logic        z_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic [15:0] mismatch,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail,
   output logic        pass
);

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t      state;
   logic [3:0]  idx;
   logic [15:0] exp_reg;
   logic [7:0]  settle_cnt;
   logic [15:0] tbl_next;
   logic [4:0]  fail_next;
   logic        row_bad;

   assign w_out = idx[3];
   assign x_out = idx[2];
   assign y_out = idx[1];
   assign z_out = idx[0];

   // Table and fail count as they will be after the current row is sampled, so the
   // final mismatch/pass can include row 15 on the same edge that enters DONE.
   always_comb begin
      tbl_next      = table_out;
      tbl_next[idx] = f_in;
      row_bad       = (f_in != exp_reg[idx]);
      fail_next     = fail_count;
      if (row_bad)
         fail_next = fail_count + 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 4'd0;
         exp_reg    <= 16'd0;
         settle_cnt <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         table_out  <= 16'd0;
         mismatch   <= 16'd0;
         fail_count <= 5'd0;
         first_fail <= 4'd0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  idx        <= 4'd0;
                  exp_reg    <= exp_table;
                  table_out  <= 16'd0;
                  mismatch   <= 16'd0;
                  fail_count <= 5'd0;
                  first_fail <= 4'd0;
                  pass       <= 1'b0;
                  settle_cnt <= 8'd0;
                  busy       <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= 8'd0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            SAMPLE: begin
               table_out  <= tbl_next;
               fail_count <= fail_next;
               if (row_bad && fail_count == 5'd0)
                  first_fail <= idx;
               // End of scan is decided on the row index, not on its wrap to 0.
               if (idx == 4'd15) begin
                  mismatch <= tbl_next ^ exp_reg;
                  pass     <= (fail_next == 5'd0);
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= WAIT;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               idx   <= 4'd0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: table of full scans plus hand-written
// sequences for ignored start, back-to-back start, mid-scan reset and a slow block.
module tb_truth_table_scanner;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] exp_tbl;
      logic [15:0] want_table;
      logic [15:0] want_mis;
      logic [4:0]  want_cnt;
      logic [3:0]  want_first;
      logic        want_pass;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] exp_table = 16'd0;
   logic [1:0]  f_mode = 2'd0;
   logic        f_in;
   logic        w_out, x_out, y_out, z_out, busy, done, pass;
   logic [15:0] table_out, mismatch;
   logic [4:0]  fail_count;
   logic [3:0]  first_fail;

   logic        start2 = 1'b0;
   logic        f_in2;
   logic        w2, x2, y2, z2, busy2, done2, pass2;
   logic [15:0] table2, mismatch2;
   logic [4:0]  fail_count2;
   logic [3:0]  first_fail2;

   logic [2:0]  pipe, pipe2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Model of the block under check: f = (~y&z)|(w&~x)|(x&y&~z), row bits are w,x,y,z.
   function automatic logic blk(input logic w, input logic x, input logic y, input logic z);
      return (~y & z) | (w & ~x) | (x & y & ~z);
   endfunction

   // Mode 0: combinational block, 1: output tied low, 2: block behind three flops.
   always_comb begin
      f_in = 1'b0;
      if (f_mode == 2'd0)
         f_in = blk(w_out, x_out, y_out, z_out);
      else if (f_mode == 2'd2)
         f_in = pipe[2];
   end
   assign f_in2 = pipe2[2];

   always @(posedge clk) begin
      pipe  <= {pipe[1:0],  blk(w_out, x_out, y_out, z_out)};
      pipe2 <= {pipe2[1:0], blk(w2, x2, y2, z2)};
   end

   truth_table_scanner #(.SETTLE(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table), .f_in(f_in),
      .w_out(w_out), .x_out(x_out), .y_out(y_out), .z_out(z_out),
      .busy(busy), .done(done), .table_out(table_out), .mismatch(mismatch),
      .fail_count(fail_count), .first_fail(first_fail), .pass(pass)
   );

   truth_table_scanner #(.SETTLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .exp_table(16'h6F62), .f_in(f_in2),
      .w_out(w2), .x_out(x2), .y_out(y2), .z_out(z2),
      .busy(busy2), .done(done2), .table_out(table2), .mismatch(mismatch2),
      .fail_count(fail_count2), .first_fail(first_fail2), .pass(pass2)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic checkResults(input string tag, input vec_t v);
      checkOutput({tag, " table_out"},  32'(table_out),  32'(v.want_table));
      checkOutput({tag, " mismatch"},   32'(mismatch),   32'(v.want_mis));
      checkOutput({tag, " fail_count"}, 32'(fail_count), 32'(v.want_cnt));
      checkOutput({tag, " first_fail"}, 32'(first_fail), 32'(v.want_first));
      checkOutput({tag, " pass"},       32'(pass),       32'(v.want_pass));
   endtask

   // Runs one scan (or two back-to-back when hold is set), checking drive, busy and
   // done every cycle; poke re-asserts start for one cycle mid-scan.
   task automatic applyStimulus(input string tag, input vec_t v, input int poke, input bit hold);
      int last;
      int c;
      logic [3:0] want_idx;
      last = hold ? 132 : 66;
      @(negedge clk);
      f_mode    = v.mode;
      exp_table = v.exp_tbl;
      start     = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= last; cyc++) begin
         #1;
         if (!hold && cyc == 1) start = 1'b0;
         if (hold && cyc == 131) start = 1'b0;
         if (poke != 0 && cyc == poke) start = 1'b1;
         if (poke != 0 && cyc == poke + 1) start = 1'b0;
         c = (cyc > 66) ? cyc - 66 : cyc;
         if (c >= 1 && c <= 64) want_idx = 4'((c - 1) / 4);
         else if (c == 65)      want_idx = 4'd15;
         else                   want_idx = 4'd0;
         checkOutput($sformatf("%s drive c%0d", tag, cyc), 32'({w_out, x_out, y_out, z_out}), 32'(want_idx));
         checkOutput($sformatf("%s done c%0d", tag, cyc), 32'(done), 32'(c == 65));
         checkOutput($sformatf("%s busy c%0d", tag, cyc), 32'(busy), 32'(c >= 1 && c <= 65));
         @(posedge clk);
      end
      checkResults(tag, v);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{2'd0, 16'h6F62, 16'h6F62, 16'h0000, 5'd0,  4'd0,  1'b1};
      vecs[1] = '{2'd0, 16'h6F63, 16'h6F62, 16'h0001, 5'd1,  4'd0,  1'b0};
      vecs[2] = '{2'd1, 16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 4'd0,  1'b0};
      vecs[3] = '{2'd2, 16'h6F62, 16'h6F62, 16'h0000, 5'd0,  4'd0,  1'b1};
      vecs[4] = '{2'd0, 16'h0000, 16'h6F62, 16'h6F62, 5'd9,  4'd1,  1'b0};
      vecs[5] = '{2'd0, 16'hEF62, 16'h6F62, 16'h8000, 5'd1,  4'd15, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset drive", 32'({w_out, x_out, y_out, z_out}), 32'd0);
      checkOutput("reset busy/done/pass", 32'({busy, done, pass}), 32'd0);
      checkOutput("reset table/mismatch", 32'({table_out, mismatch}), 32'd0);
      checkOutput("reset count/first", 32'({fail_count, first_fail}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      for (int i = 0; i < 6; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i], 0, 1'b0);

      applyStimulus("poke", vecs[1], 20, 1'b0);
      applyStimulus("hold", vecs[0], 0, 1'b1);

      // Mid-scan reset at cycle 30: outputs clear without waiting for an edge.
      @(negedge clk);
      f_mode = 2'd0; exp_table = 16'h6F62; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (29) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async rst drive", 32'({w_out, x_out, y_out, z_out}), 32'd0);
      checkOutput("async rst busy/done/pass", 32'({busy, done, pass}), 32'd0);
      checkOutput("async rst table/mismatch", 32'({table_out, mismatch}), 32'd0);
      checkOutput("async rst count/first", 32'({fail_count, first_fail}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("aborted busy/done c%0d", cyc), 32'({busy, done}), 32'd0);
      end
      applyStimulus("after rst", vecs[0], 0, 1'b0);

      // Three-flop block against SETTLE=2: each row sees the previous row's response.
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      for (int cyc = 1; cyc <= 50; cyc++) begin
         if (cyc > 1) #1;
         checkOutput($sformatf("slow done c%0d", cyc), 32'(done2), 32'(cyc == 49));
         @(posedge clk);
      end
      #1;
      checkOutput("slow table_out", 32'(table2), 32'h0000DEC4);
      checkOutput("slow mismatch", 32'(mismatch2), 32'h0000B1A6);
      checkOutput("slow fail_count", 32'(fail_count2), 32'd8);
      checkOutput("slow first_fail", 32'(first_fail2), 32'd1);
      checkOutput("slow pass", 32'(pass2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
